// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline register with a two-entry skid buffer and a registered in_ready.
// Also emits a one-cycle branch redirect pulse when a taken branch is accepted.
module ex_mem_skid #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     alu_out,
    input  logic                      eq,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [REG_ADDR_WIDTH-1:0] rd,
    input  logic                      reg_write,
    input  logic                      mem_write,
    input  logic [1:0]                result_src,
    input  logic                      branch,
    input  logic [DATA_WIDTH-1:0]     br_target,

    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_alu_out,
    output logic                      out_eq,
    output logic [DATA_WIDTH-1:0]     out_wdata,
    output logic [REG_ADDR_WIDTH-1:0] out_rd,
    output logic                      out_reg_write,
    output logic                      out_mem_write,
    output logic [1:0]                out_result_src,
    output logic                      out_branch,
    output logic [DATA_WIDTH-1:0]     out_br_target,

    input  logic                      flush,
    output logic                      br_taken,
    output logic [DATA_WIDTH-1:0]     br_pc,
    output logic [1:0]                occupancy
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     alu_out;
        logic                      eq;
        logic [DATA_WIDTH-1:0]     wdata;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      reg_write;
        logic                      mem_write;
        logic [1:0]                result_src;
        logic                      branch;
        logic [DATA_WIDTH-1:0]     br_target;
    } entry_t;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    entry_t                main_q, main_d;
    entry_t                skid_q, skid_d;
    logic                  in_ready_q, in_ready_d;
    logic                  br_taken_q, br_taken_d;
    logic [DATA_WIDTH-1:0] br_pc_q, br_pc_d;

    entry_t in_entry;
    logic   accept;
    logic   xfer;

    assign in_entry = '{
        alu_out:    alu_out,
        eq:         eq,
        wdata:      wdata,
        rd:         rd,
        reg_write:  reg_write,
        mem_write:  mem_write,
        result_src: result_src,
        branch:     branch,
        br_target:  br_target
    };

    assign accept = in_valid && in_ready_q;
    assign xfer   = (state_q != StEmpty) && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    main_d  = in_entry;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (accept && xfer) begin
                    main_d = in_entry;
                end else if (accept) begin
                    skid_d  = in_entry;
                    state_d = StFull;
                end else if (xfer) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (xfer) begin
                    main_d  = skid_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (flush) begin
            state_d = StEmpty;
        end
        // Registered so in_ready never depends combinationally on out_ready.
        in_ready_d = (state_d != StFull);
        br_taken_d = accept && branch && eq && !flush;
        br_pc_d    = br_taken_d ? br_target : br_pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            br_taken_q <= 1'b0;
            br_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            br_taken_q <= br_taken_d;
            br_pc_q    <= br_pc_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = (state_q != StEmpty);
    assign occupancy      = state_q;
    assign br_taken       = br_taken_q;
    assign br_pc          = br_pc_q;
    assign out_alu_out    = main_q.alu_out;
    assign out_eq         = main_q.eq;
    assign out_wdata      = main_q.wdata;
    assign out_rd         = main_q.rd;
    assign out_reg_write  = main_q.reg_write;
    assign out_mem_write  = main_q.mem_write;
    assign out_result_src = main_q.result_src;
    assign out_branch     = main_q.branch;
    assign out_br_target  = main_q.br_target;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed bench for ex_mem_skid: streaming, backpressure, flush, branch redirect, reset.
module tb_ex_mem_skid;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [DW-1:0] alu_out, wdata, br_target;
    logic          eq, reg_write, mem_write, branch;
    logic [AW-1:0] rd;
    logic [1:0]    result_src;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_alu_out, out_wdata, out_br_target;
    logic          out_eq, out_reg_write, out_mem_write, out_branch;
    logic [AW-1:0] out_rd;
    logic [1:0]    out_result_src;
    logic          flush, br_taken;
    logic [DW-1:0] br_pc;
    logic [1:0]    occupancy;

    int n_cmp = 0;
    int n_err = 0;

    ex_mem_skid #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .eq(eq), .wdata(wdata), .rd(rd),
        .reg_write(reg_write), .mem_write(mem_write), .result_src(result_src),
        .branch(branch), .br_target(br_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_out(out_alu_out), .out_eq(out_eq), .out_wdata(out_wdata), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_mem_write(out_mem_write),
        .out_result_src(out_result_src), .out_branch(out_branch),
        .out_br_target(out_br_target),
        .flush(flush), .br_taken(br_taken), .br_pc(br_pc), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [1:0] occ, input logic ov,
                               input logic ir);
        check_eq({tag, ".occ"}, 64'(occupancy), 64'(occ));
        check_eq({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
        check_eq({tag, ".in_ready"}, 64'(in_ready), 64'(ir));
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        alu_out = '0; eq = 1'b0; wdata = '0; rd = '0; reg_write = 1'b0;
        mem_write = 1'b0; result_src = 2'd0; branch = 1'b0; br_target = '0;

        #12;
        check_state("reset", 2'd0, 1'b0, 1'b1);
        check_eq("reset.br_taken", 64'(br_taken), 64'd0);
        check_eq("reset.br_pc", 64'(br_pc), 64'd0);
        check_eq("reset.out_reg_write", 64'(out_reg_write), 64'd0);
        check_eq("reset.out_mem_write", 64'(out_mem_write), 64'd0);
        rst_n = 1'b1;
        tick();

        // Streaming: 1..8 emerge one cycle late, occupancy stays at 1.
        in_valid = 1'b1; out_ready = 1'b1; reg_write = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            alu_out = DW'(i);
            rd = AW'(i + 3);
            wdata = DW'(i * 16);
            tick();
            check_eq("stream.alu_out", 64'(out_alu_out), 64'(i));
            check_eq("stream.rd", 64'(out_rd), 64'(i + 3));
            check_eq("stream.wdata", 64'(out_wdata), 64'(i * 16));
            check_state("stream", 2'd1, 1'b1, 1'b1);
        end
        in_valid = 1'b0; reg_write = 1'b0;
        tick();
        check_state("stream.drain", 2'd0, 1'b0, 1'b1);

        // Backpressure: 0xA then 0xB fill both slots, 0xC must be ignored.
        out_ready = 1'b0; in_valid = 1'b1; alu_out = 32'hA; mem_write = 1'b1;
        tick();
        check_state("bp.one", 2'd1, 1'b1, 1'b1);
        check_eq("bp.one.alu", 64'(out_alu_out), 64'hA);
        check_eq("bp.one.mem_write", 64'(out_mem_write), 64'd1);
        alu_out = 32'hB; mem_write = 1'b0;
        tick();
        check_state("bp.full", 2'd2, 1'b1, 1'b0);
        check_eq("bp.full.alu", 64'(out_alu_out), 64'hA);
        alu_out = 32'hC;
        tick();
        check_state("bp.hold", 2'd2, 1'b1, 1'b0);
        check_eq("bp.hold.alu", 64'(out_alu_out), 64'hA);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check_state("bp.pop1", 2'd1, 1'b1, 1'b1);
        check_eq("bp.pop1.alu", 64'(out_alu_out), 64'hB);
        check_eq("bp.pop1.mem_write", 64'(out_mem_write), 64'd0);
        tick();
        check_state("bp.pop2", 2'd0, 1'b0, 1'b1);

        // Flush while FULL with simultaneous in_valid and out_ready.
        out_ready = 1'b0; in_valid = 1'b1; alu_out = 32'h11;
        tick();
        alu_out = 32'h22;
        tick();
        check_state("fl.full", 2'd2, 1'b1, 1'b0);
        alu_out = 32'h33; out_ready = 1'b1; flush = 1'b1;
        tick();
        check_state("fl.after", 2'd0, 1'b0, 1'b1);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check_state("fl.idle", 2'd0, 1'b0, 1'b1);
        out_ready = 1'b0; in_valid = 1'b1; alu_out = 32'h44;
        tick();
        check_state("fl.next", 2'd1, 1'b1, 1'b1);
        check_eq("fl.next.alu", 64'(out_alu_out), 64'h44);
        // Flush in ONE discards the in-cycle accept as well.
        alu_out = 32'h77; flush = 1'b1;
        tick();
        check_state("fl.one", 2'd0, 1'b0, 1'b1);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check_state("fl.one.idle", 2'd0, 1'b0, 1'b1);

        // Branch redirect.
        out_ready = 1'b1; in_valid = 1'b1; branch = 1'b1; eq = 1'b1;
        br_target = 32'h0000_0040; alu_out = 32'h1;
        tick();
        check_eq("br.taken", 64'(br_taken), 64'd1);
        check_eq("br.pc", 64'(br_pc), 64'h40);
        check_eq("br.out_branch", 64'(out_branch), 64'd1);
        in_valid = 1'b0; branch = 1'b0; eq = 1'b0;
        tick();
        check_eq("br.pulse_end", 64'(br_taken), 64'd0);
        check_eq("br.pc_hold", 64'(br_pc), 64'h40);
        in_valid = 1'b1; branch = 1'b1; eq = 1'b0; br_target = 32'h80;
        tick();
        check_eq("br.not_eq", 64'(br_taken), 64'd0);
        check_eq("br.not_eq.pc", 64'(br_pc), 64'h40);
        eq = 1'b1; br_target = 32'hC0; flush = 1'b1;
        tick();
        check_eq("br.flushed", 64'(br_taken), 64'd0);
        check_eq("br.flushed.pc", 64'(br_pc), 64'h40);
        flush = 1'b0; in_valid = 1'b0; branch = 1'b0; eq = 1'b0;
        tick();

        // Asynchronous reset mid-cycle while FULL with a redirect pending.
        out_ready = 1'b0; in_valid = 1'b1; alu_out = 32'h1; reg_write = 1'b1;
        tick();
        alu_out = 32'h2; branch = 1'b1; eq = 1'b1; br_target = 32'h100;
        tick();
        check_state("rst.full", 2'd2, 1'b1, 1'b0);
        check_eq("rst.pre.br_taken", 64'(br_taken), 64'd1);
        in_valid = 1'b0; branch = 1'b0; eq = 1'b0; reg_write = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_state("rst.async", 2'd0, 1'b0, 1'b1);
        check_eq("rst.async.br_taken", 64'(br_taken), 64'd0);
        check_eq("rst.async.br_pc", 64'(br_pc), 64'd0);
        check_eq("rst.async.reg_write", 64'(out_reg_write), 64'd0);
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        in_valid = 1'b1; alu_out = 32'h55;
        tick();
        check_state("rst.after", 2'd1, 1'b1, 1'b1);
        check_eq("rst.after.alu", 64'(out_alu_out), 64'h55);
        in_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ex_mem_skid.md
EX_MEM_SKID -- requirements
Module: ex_mem_skid

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of ALU result, store data and branch target.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5, width of destination register index.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1: execute-stage handshake; a transfer occurs when both are 1 on a clock edge.
REQ-006 SHALL have input payload: alu_out DATA_WIDTH (ALU result), eq 1 (ALU equality flag), wdata DATA_WIDTH (store data), rd REG_ADDR_WIDTH, reg_write 1, mem_write 1, result_src 2, branch 1, br_target DATA_WIDTH.
REQ-007 SHALL have ports out_valid output 1 and out_ready input 1: memory-stage handshake; a transfer occurs when both are 1 on a clock edge.
REQ-008 SHALL have output payload with the same names, widths and meanings as REQ-006, prefixed out_.
REQ-009 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-010 SHALL have ports br_taken output 1 (one-cycle redirect pulse) and br_pc output DATA_WIDTH (redirect address).
REQ-011 SHALL have port occupancy  output  2  number of held entries (0..2).

Function
REQ-012 SHALL hold up to two entries: main register (drives out_*) and skid register; states EMPTY (0), ONE (1), FULL (2).
REQ-013 SHALL drive in_ready = 1 when the skid register is empty, as a registered value with no combinational path from out_ready.
REQ-014 SHALL drive out_valid = 1 exactly when the main register is occupied; out_* payload SHALL stay stable while out_valid=1 and out_ready=0.
REQ-015 SHALL give an accepted entry one-cycle latency: accepted into EMPTY, it appears on out_* the next cycle.
REQ-016 EMPTY: accept -> ONE (entry loaded into main).
REQ-017 ONE: accept without output transfer -> FULL (entry loaded into skid, in_ready falls next cycle); accept with output transfer -> ONE (new entry loaded into main); output transfer only -> EMPTY.
REQ-018 FULL: output transfer -> ONE (skid entry moves to main); no transfer -> FULL, no change; in_valid is ignored because in_ready=0.
REQ-019 SHALL preserve strict FIFO order; no entry SHALL be dropped or duplicated except by flush.
REQ-020 flush=1 on an edge SHALL clear both occupancies (state EMPTY, in_ready=1 next cycle), overriding any simultaneous accept or output transfer; the in-cycle accept is discarded.
REQ-021 On accepting an entry with branch=1 and eq=1 (flush=0), SHALL assert br_taken=1 for exactly the next cycle with br_pc = that entry's br_target; br_taken SHALL be 0 otherwise.
REQ-022 br_pc SHALL hold its last value when br_taken=0.
REQ-023 Payload registers SHALL load only on accept/move; data regs need not be reset.

Reset
REQ-024 While rst_n=0, asynchronously: state EMPTY, out_valid=0, in_ready=1, occupancy=0, br_taken=0, br_pc=0, out_reg_write=0, out_mem_write=0.
REQ-025 Reset asserted mid-operation SHALL discard all held entries; the first accept after rst_n rises behaves as from EMPTY.

Verification
REQ-026 Streaming: in_valid=1 and out_ready=1 for 8 cycles with alu_out=1..8 -> out_alu_out=1..8 in order, one cycle late, occupancy stays 1, in_ready stays 1.
REQ-027 Backpressure: out_ready=0, accept alu_out=0xA then 0xB -> occupancy=2, in_ready=0, out_alu_out=0xA held; out_ready=1 -> 0xA then 0xB emitted, in_ready=1 one cycle after first transfer.
REQ-028 Flush while FULL with in_valid=1 and out_ready=1 in the same cycle -> next cycle occupancy=0, out_valid=0, in_ready=1; no flushed or in-cycle entry ever appears on out_*.
REQ-029 Branch: accept branch=1, eq=1, br_target=0x0000_0040 -> br_taken=1 for one cycle, br_pc=0x40; branch=1, eq=0 -> br_taken stays 0; same taken branch with flush=1 -> br_taken stays 0.
REQ-030 Reset: rst_n=0 asserted asynchronously mid-cycle while FULL -> outputs take REQ-024 values immediately; after release, single accept of 0x55 -> out_alu_out=0x55 next cycle.
